// File: rtl/montgomery_power_select.sv
// -----------------------------------------------------------------------------
// montgomery_power_select
//
// Sits between the Montgomery squarer stream and the modular-product
// accumulator. The squarer delivers x, x^2, x^4, ... x^(2^(HIGHEST_EXPONENT-1)).
// Each power arrives as NUM_BLOCKS blocks, LSB block first. A power is
// forwarded only when its exponent bit is 1. The exponent arrives as
// REGISTER_SIZE-bit words. Each word is released with a consumed pulse.
//
// Optional feature (macro POWER_SELECT_COUNT_EN):
//   Adds selected_count_out, the number of powers forwarded in the current
//   exponentiation. The value holds through done_out. It clears when the
//   next run starts.
//
// Ports:
//   clk_in                 clock
//   rst_in                 synchronous active-high reset
//   power_block_in         power block from squarer
//   power_valid_in         power_block_in valid this cycle
//   exponent_block_in      current exponent word, LSB = lowest power index
//   consumed_exponent_out  pulse: current exponent word fully used
//   selected_block_out     forwarded power block (0 when not valid)
//   selected_valid_out     selected_block_out valid
//   selected_last_out      final block of a forwarded power
//   done_out               pulse: all HIGHEST_EXPONENT powers processed
//   selected_count_out     (POWER_SELECT_COUNT_EN only) forwarded power count
//
// All outputs are registered. Latency is one cycle from the input block.
// -----------------------------------------------------------------------------
module montgomery_power_select #(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM   = 2048,
    parameter int NUM_BLOCKS    = 2 * BITS_IN_NUM / REGISTER_SIZE
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [REGISTER_SIZE-1:0] power_block_in,
    input  logic                     power_valid_in,
    input  logic [REGISTER_SIZE-1:0] exponent_block_in,
    output logic                     consumed_exponent_out,
    output logic [REGISTER_SIZE-1:0] selected_block_out,
    output logic                     selected_valid_out,
    output logic                     selected_last_out,
    output logic                     done_out
`ifdef POWER_SELECT_COUNT_EN
    ,
    output logic [$clog2(BITS_IN_NUM):0] selected_count_out
`endif
);

    localparam int HIGHEST_EXPONENT = BITS_IN_NUM;
    localparam int BLK_W = $clog2(NUM_BLOCKS);
    localparam int PWR_W = $clog2(HIGHEST_EXPONENT);
    localparam int IDX_W = $clog2(REGISTER_SIZE);
    localparam int unsigned RS_U = REGISTER_SIZE;

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [BLK_W-1:0]         r_block_ctr;
    logic [PWR_W-1:0]         r_power_ctr;
    logic [REGISTER_SIZE-1:0] r_sel_block;
    logic                     r_sel_valid;
    logic                     r_sel_last;
    logic                     r_consumed;
    logic                     r_done;

    logic [IDX_W-1:0] w_bit_idx;
    logic             w_sel_bit;
    logic             w_last_blk;
    logic             w_last_pow;
    logic             w_last_word_bit;
    logic             w_fwd;
    logic             w_run_end;
    logic             w_run_start;

    // Bit position of the current power within the current exponent word.
    assign w_bit_idx       = IDX_W'(32'(r_power_ctr) % RS_U);
    assign w_sel_bit       = exponent_block_in[w_bit_idx];
    assign w_last_blk      = (r_block_ctr == BLK_W'(NUM_BLOCKS - 1));
    assign w_last_pow      = (r_power_ctr == PWR_W'(HIGHEST_EXPONENT - 1));
    assign w_last_word_bit = (w_bit_idx == IDX_W'(REGISTER_SIZE - 1));
    assign w_fwd           = power_valid_in && w_sel_bit;
    assign w_run_end       = power_valid_in && w_last_blk && w_last_pow;
    // A valid block seen in IDLE is block 0 of power 0 of a new run.
    assign w_run_start     = power_valid_in && (r_state == S_IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (power_valid_in) w_state_nxt = S_STREAM;
            S_STREAM: if (w_run_end)      w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        // This handles a one-block, one-power configuration.
        if (w_run_end) w_state_nxt = S_IDLE;
    end

    // ---------------- counters ----------------
    // Both counters wrap to 0 at the end of a run. A block arriving on the
    // done_out cycle then starts the next run with no bubble.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_block_ctr <= '0;
            r_power_ctr <= '0;
        end else if (power_valid_in) begin
            if (w_last_blk) begin
                r_block_ctr <= '0;
                r_power_ctr <= w_last_pow ? '0 : r_power_ctr + 1'b1;
            end else begin
                r_block_ctr <= r_block_ctr + 1'b1;
            end
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sel_block <= '0;
            r_sel_valid <= 1'b0;
            r_sel_last  <= 1'b0;
            r_consumed  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_sel_block <= w_fwd ? power_block_in : '0;
            r_sel_valid <= w_fwd;
            r_sel_last  <= w_fwd && w_last_blk;
            r_consumed  <= power_valid_in && w_last_blk && w_last_word_bit;
            r_done      <= w_run_end;
        end
    end

    assign selected_block_out    = r_sel_block;
    assign selected_valid_out    = r_sel_valid;
    assign selected_last_out     = r_sel_last;
    assign consumed_exponent_out = r_consumed;
    assign done_out              = r_done;

`ifdef POWER_SELECT_COUNT_EN
    logic [$clog2(BITS_IN_NUM):0] r_count;

    // A new run replaces the count. Its first block can itself complete a
    // forwarded power when NUM_BLOCKS is 1.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_count <= '0;
        end else if (w_run_start) begin
            r_count <= (w_fwd && w_last_blk) ? 1 : 0;
        end else if (w_fwd && w_last_blk) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign selected_count_out = r_count;
`endif

endmodule

// File: tb/tb_montgomery_power_select.sv
module tb_montgomery_power_select;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Small config: REGISTER_SIZE=4, BITS_IN_NUM=8 -> NUM_BLOCKS=4, HE=8
    logic [3:0] s_din = '0;
    logic       s_vin = 1'b0;
    logic [3:0] s_exp = '0;
    logic       s_cons, s_valid, s_last, s_done;
    logic [3:0] s_block;

    // Medium config: REGISTER_SIZE=32, BITS_IN_NUM=256 -> NUM_BLOCKS=16, HE=256
    logic [31:0] m_din = '0;
    logic        m_vin = 1'b0;
    logic [31:0] m_exp = '0;
    logic        m_cons, m_valid, m_last, m_done;
    logic [31:0] m_block;

`ifdef POWER_SELECT_COUNT_EN
    logic [3:0] s_cnt;
    logic [8:0] m_cnt;
`endif

    montgomery_power_select #(.REGISTER_SIZE(4), .BITS_IN_NUM(8)) u_small (
        .clk_in(clk), .rst_in(rst),
        .power_block_in(s_din), .power_valid_in(s_vin),
        .exponent_block_in(s_exp), .consumed_exponent_out(s_cons),
        .selected_block_out(s_block), .selected_valid_out(s_valid),
        .selected_last_out(s_last), .done_out(s_done)
`ifdef POWER_SELECT_COUNT_EN
        , .selected_count_out(s_cnt)
`endif
    );

    montgomery_power_select #(.REGISTER_SIZE(32), .BITS_IN_NUM(256)) u_med (
        .clk_in(clk), .rst_in(rst),
        .power_block_in(m_din), .power_valid_in(m_vin),
        .exponent_block_in(m_exp), .consumed_exponent_out(m_cons),
        .selected_block_out(m_block), .selected_valid_out(m_valid),
        .selected_last_out(m_last), .done_out(m_done)
`ifdef POWER_SELECT_COUNT_EN
        , .selected_count_out(m_cnt)
`endif
    );

    typedef struct packed { logic [3:0] blk; logic last; } s_item_t;
    typedef struct packed { logic [31:0] blk; logic last; } m_item_t;
    s_item_t sq[$];
    m_item_t mq[$];

    int s_sel_n = 0, s_last_n = 0, s_cons_n = 0, s_done_n = 0, s_exp_cnt = 0;
    int m_sel_n = 0, m_last_n = 0, m_cons_n = 0, m_done_n = 0, m_exp_cnt = 0;

    task automatic check_eq(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        s_item_t e;
        nvec++;
        if (s_valid) begin
            s_sel_n++;
            if (s_last) s_last_n++;
            if (sq.size() == 0) begin
                nerr++;
                $display("FAIL small_unexpected: got blk=%h last=%b, none expected", s_block, s_last);
            end else begin
                e = sq.pop_front();
                if (s_block !== e.blk || s_last !== e.last) begin
                    nerr++;
                    $display("FAIL small_block: got blk=%h last=%b expected blk=%h last=%b",
                             s_block, s_last, e.blk, e.last);
                end
            end
        end else if (s_block !== 4'h0 || s_last !== 1'b0) begin
            nerr++;
            $display("FAIL small_idle: got blk=%h last=%b expected 0/0", s_block, s_last);
        end
        if (s_cons) s_cons_n++;
        if (s_done) begin
            s_done_n++;
            check_eq("small_done_with_consumed", int'(s_cons), 1);
`ifdef POWER_SELECT_COUNT_EN
            check_eq("small_count_at_done", int'(s_cnt), s_exp_cnt);
`endif
        end
    end

    always @(negedge clk) begin
        m_item_t e;
        if (m_valid) begin
            nvec++;
            m_sel_n++;
            if (m_last) m_last_n++;
            if (mq.size() == 0) begin
                nerr++;
                $display("FAIL med_unexpected: got blk=%h, none expected", m_block);
            end else begin
                e = mq.pop_front();
                if (m_block !== e.blk || m_last !== e.last) begin
                    nerr++;
                    $display("FAIL med_block: got blk=%h last=%b expected blk=%h last=%b",
                             m_block, m_last, e.blk, e.last);
                end
            end
        end
        if (m_cons) m_cons_n++;
        if (m_done) begin
            m_done_n++;
`ifdef POWER_SELECT_COUNT_EN
            check_eq("med_count_at_done", int'(m_cnt), m_exp_cnt);
`endif
        end
    end

    // ---------------- stimulus ----------------
    // Blocks are driven in order. The selection rule for the expected queue
    // is the exponent bit of the power being driven.
    task automatic drive_small(input logic [3:0] w0, input logic [3:0] w1,
                               input int gap_max, input int nblk);
        for (int i = 0; i < nblk; i++) begin
            int p, b, g;
            p = i / 4;
            b = i % 4;
            if (gap_max > 0) begin
                g = $urandom_range(0, gap_max);
                if (g > 0) begin
                    s_vin = 1'b0;
                    s_din = '0;
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
            s_exp = (p < 4) ? w0 : w1;
            s_din = 4'(i * 7 + 3);
            s_vin = 1'b1;
            if (s_exp[p % 4]) sq.push_back('{blk: s_din, last: (b == 3)});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_small(input int n);
        s_vin = 1'b0;
        s_din = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_small;
        s_sel_n = 0; s_last_n = 0; s_cons_n = 0; s_done_n = 0;
    endtask

    task automatic check_small(input string t, input int sel, input int last,
                               input int cons, input int done);
        check_eq({t, "_selected"}, s_sel_n, sel);
        check_eq({t, "_last"}, s_last_n, last);
        check_eq({t, "_consumed"}, s_cons_n, cons);
        check_eq({t, "_done"}, s_done_n, done);
        check_eq({t, "_queue_left"}, sq.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_valid", int'(s_valid), 0);
        check_eq("reset_last", int'(s_last), 0);
        check_eq("reset_block", int'(s_block), 0);
        check_eq("reset_consumed", int'(s_cons), 0);
        check_eq("reset_done", int'(s_done), 0);
`ifdef POWER_SELECT_COUNT_EN
        check_eq("reset_count", int'(s_cnt), 0);
`endif
        rst = 1'b0;
        idle_small(2);

        // 0101 / 1000, contiguous: powers 0, 2 and 7 are selected.
        clear_small(); s_exp_cnt = 3;
        drive_small(4'b0101, 4'b1000, 0, 32);
        idle_small(4);
        check_small("contig", 12, 3, 2, 1);

        // The same stimulus with random gaps of 0-3 cycles.
        clear_small(); s_exp_cnt = 3;
        drive_small(4'b0101, 4'b1000, 3, 32);
        idle_small(4);
        check_small("gaps", 12, 3, 2, 1);

        // Exponent zero: nothing forwarded, but the bookkeeping pulses still occur.
        clear_small(); s_exp_cnt = 0;
        drive_small(4'b0000, 4'b0000, 0, 32);
        idle_small(4);
        check_small("zero", 0, 0, 2, 1);

        // All ones for two runs back-to-back with no gap.
        clear_small(); s_exp_cnt = 8;
        drive_small(4'b1111, 4'b1111, 0, 32);
        drive_small(4'b1111, 4'b1111, 0, 32);
        idle_small(4);
        check_small("b2b", 64, 16, 4, 2);

        // Abort after 10 blocks: p0 and p2 blocks 0-1 come out. Then a fresh
        // run forwards only p0.
        clear_small(); s_exp_cnt = 1;
        drive_small(4'b0101, 4'b1000, 0, 10);
        s_vin = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("midrst_valid", int'(s_valid), 0);
        drive_small(4'b0001, 4'b0000, 0, 32);
        idle_small(4);
        check_small("midrst", 10, 2, 2, 1);

        // Medium config, top exponent bit only: power 255 is forwarded.
        m_exp_cnt = 1;
        for (int i = 0; i < 4096; i++) begin
            int p, b;
            p = i / 16;
            b = i % 16;
            m_exp = (p / 32 == 7) ? 32'h8000_0000 : 32'h0;
            m_din = 32'(i * 7 + 3);
            m_vin = 1'b1;
            if (m_exp[p % 32]) mq.push_back('{blk: m_din, last: (b == 15)});
            @(posedge clk);
            #1;
        end
        m_vin = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("med_selected", m_sel_n, 16);
        check_eq("med_last", m_last_n, 1);
        check_eq("med_consumed", m_cons_n, 8);
        check_eq("med_done", m_done_n, 1);
        check_eq("med_queue_left", mq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
